// File: rtl/clk_div_pkg.sv
// Purpose : shared defaults and helpers for the clock-divider bank.
// Latency : n/a (constants and a width function only).
// Backpressure: n/a.
package clk_div_pkg;

    // Default counter/divisor width and reset divisor for a full-size build.
    localparam int DEF_CNT_W = 25;
    localparam int DEF_DIV   = 100000;

    // Select-bus width for a bank of n channels: max(1, clog2(n)).
    function automatic int sel_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// Purpose : one divider channel -- counter, active/shadow divisor, tick and toggle outputs.
// Latency : tick/clk_out registered; they update on the terminal-count edge (D+1 edges into a period).
// Backpressure: none; writes are always accepted, and a running channel defers them to its next terminal count.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   en              run enable (low clears the count and the outputs)
//   sync_clr        restart the channel and apply any pending divisor
//   wr_en, wr_val   decoded divisor write strobe and value
//   tick            one-cycle pulse per period
//   clk_out         toggles once per period
//   pend            a shadow divisor is waiting for the next terminal count
module clk_div_ch #(
    parameter int CNT_W       = 25,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_val,
    output logic             tick,
    output logic             clk_out,
    output logic             pend
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             terminal;

    // The count runs 0..act inclusive, so a period is act+1 edges and the
    // counter can never pass act (no wrap even for act = all ones).
    assign terminal = (cnt_q == act_q);

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        tick_d = tick_q;
        clk_d  = clk_q;

        if (sync_clr) begin
            cnt_d  = '0;
            tick_d = 1'b0;
            clk_d  = 1'b0;
            if (pend_q) begin
                act_d = shd_q;
            end
            pend_d = 1'b0;
            // A write in the same cycle as the restart takes effect at once
            // and supersedes any shadow value just applied.
            if (wr_en) begin
                act_d = wr_val;
            end
        end else if (!en) begin
            // Idle: partial count is discarded; divisor/pend state retained.
            cnt_d  = '0;
            tick_d = 1'b0;
            clk_d  = 1'b0;
            if (wr_en) begin
                act_d  = wr_val;
                pend_d = 1'b0;
            end
        end else begin
            if (terminal) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                clk_d  = ~clk_q;
                if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                tick_d = 1'b0;
            end
            // Running channel: park the new value in the shadow. On a terminal
            // edge the older shadow was just applied above; this one waits for
            // the following terminal count.
            if (wr_en) begin
                shd_d  = wr_val;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            act_q  <= DIV_RST;
            shd_q  <= DIV_RST;
            pend_q <= 1'b0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_q;
    assign pend    = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Purpose : bank of NUM_CH runtime-programmable clock dividers with glitch-free divisor update and common restart.
// Latency : outputs registered; each channel ticks D+1 edges after enable/restart, then every D+1 cycles.
// Backpressure: none; out-of-range divisor writes are dropped.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   en[NUM_CH]      per-channel run enable
//   sync_clr        restart every channel in the same cycle
//   div_we/div_sel/div_val   divisor write strobe, target channel, value D
//   tick[NUM_CH]    one-cycle pulse per period (D+1 cycles)
//   clk_out[NUM_CH] toggle output, full period 2*(D+1)
//   div_pend[NUM_CH] shadow divisor waiting to be applied
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int CNT_W       = DEF_CNT_W,
    parameter  int DEFAULT_DIV = DEF_DIV,
    localparam int SEL_W       = sel_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              div_we,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] div_pend
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [SEL_W-1:0] IDX = SEL_W'(i);

        // A select value at or above NUM_CH matches no channel, so such a
        // write changes nothing.
        logic wr_en;
        assign wr_en = div_we && (div_sel == IDX);

        clk_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[i]),
            .sync_clr (sync_clr),
            .wr_en    (wr_en),
            .wr_val   (div_val),
            .tick     (tick[i]),
            .clk_out  (clk_out[i]),
            .pend     (div_pend[i])
        );
    end

endmodule
